// File: rtl/signed_seq_divider.sv
// Signed 32/16 sequential divider: 32-cycle radix-2 restoring loop on operand
// magnitudes, then a sign-fix cycle. Quotient truncates toward zero; remainder follows the dividend's sign.
module signed_seq_divider #(
    parameter int N_ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        ovf,
    output logic        dbz
);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, FIX} state_t;

    state_t      state, state_nxt;
    logic [31:0] dvd_r;
    logic [15:0] dvs_r;
    logic [31:0] acc;      // dividend magnitude shifts out MSB-first, quotient bits shift in
    logic [15:0] dmag;
    logic [32:0] prem;
    logic        qneg, rneg;
    logic [5:0]  cnt;

    logic        accept, last_iter;
    logic [33:0] trial;
    logic        fits;
    logic [32:0] qmag, qsgn;
    logic [15:0] rsgn;
    logic        ovf_c;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt == 6'(N_ITER - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)     state_nxt = LOAD;
            LOAD:                state_nxt = DIV;
            DIV:  if (last_iter) state_nxt = FIX;
            FIX:                 state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // One restoring step: shift next dividend bit into the partial remainder, try a subtract.
    assign trial = {1'b0, prem[31:0], acc[31]} - {18'b0, dmag};
    assign fits  = ~trial[33];

    assign qmag  = {1'b0, acc};
    assign qsgn  = qneg ? (~qmag + 33'd1) : qmag;
    assign rsgn  = rneg ? (~prem[15:0] + 16'd1) : prem[15:0];
    assign ovf_c = qneg ? (acc > 32'h0000_8000) : (acc > 32'h0000_7FFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r <= '0;
            dvs_r <= '0;
            acc   <= '0;
            dmag  <= '0;
            prem  <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dvd_r <= dividend;
                    dvs_r <= divisor;
                end
                LOAD: begin
                    // Two's-complement negate in the operand width yields the unsigned
                    // magnitude even for the most negative value.
                    acc  <= dvd_r[31] ? (~dvd_r + 32'd1) : dvd_r;
                    dmag <= dvs_r[15] ? (~dvs_r + 16'd1) : dvs_r;
                    qneg <= dvd_r[31] ^ dvs_r[15];
                    rneg <= dvd_r[31];
                    prem <= '0;
                    cnt  <= '0;
                end
                DIV: begin
                    prem <= fits ? trial[32:0] : {prem[31:0], acc[31]};
                    acc  <= {acc[30:0], fits};
                    cnt  <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Results change only on the done cycle and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                if (dmag == 16'd0) begin
                    quotient  <= '0;
                    remainder <= dvd_r[15:0];
                    ovf       <= 1'b0;
                    dbz       <= 1'b1;
                end else begin
                    quotient  <= qsgn[15:0];
                    remainder <= rsgn;
                    ovf       <= ovf_c;
                    dbz       <= 1'b0;
                end
            end
        end
    end

endmodule
